// File: rtl/freq_measure_ctrl.sv
// rtl/freq_measure_ctrl.sv - measurement sequencer for the freq_detector period datapath
//
// Restarts the detector, waits (with timeout) for det_stable, takes NUM_SAMPLES
// period readings SAMPLE_GAP cycles apart, checks their max-min spread and
// publishes the truncated average over a valid/ready handshake. A spread
// failure re-measures up to MAX_RETRY times. Single-shot or continuous.
//
// Optional feature macro: FREQ_MEAS_RANGE_CHECK_EN
//   adds parameters MIN_PERIOD/MAX_PERIOD and output err_range; an average
//   outside [MIN_PERIOD, MAX_PERIOD] is retried like a spread failure.
//
// Ports:
//   adc_clk        clock, rising edge
//   rst            synchronous active-high reset
//   start          one-cycle request, accepted in IDLE only
//   continuous     latched at start; re-arm after each result handshake
//   stop           abort to IDLE from any state
//   det_stable     detector stable flag
//   det_period     detector period reading
//   det_clear      holds the detector in reset while high
//   result_period  averaged period, held while result_valid
//   result_valid   result available
//   result_ready   host accepts the result
//   busy           high in every state except IDLE
//   err_timeout    sticky: det_stable never arrived
//   err_spread     sticky: spread failures exhausted the retries
//   retry_cnt      retries used in the current or last measurement
//   err_range      (optional) sticky: range failures exhausted the retries
module freq_measure_ctrl #(
    parameter int PERIOD_W       = 12,
    parameter int NUM_SAMPLES    = 4,
    parameter int SAMPLE_GAP     = 256,
    parameter int STABLE_TIMEOUT = 65535,
    parameter int TOL            = 4,
    parameter int MAX_RETRY      = 3,
    parameter int CLEAR_CYCLES   = 4
`ifdef FREQ_MEAS_RANGE_CHECK_EN
    ,
    parameter int MIN_PERIOD     = 8,
    parameter int MAX_PERIOD     = 4000
`endif
) (
    input  logic                              adc_clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              continuous,
    input  logic                              stop,
    input  logic                              det_stable,
    input  logic [PERIOD_W-1:0]               det_period,
    output logic                              det_clear,
    output logic [PERIOD_W-1:0]               result_period,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic                              busy,
    output logic                              err_timeout,
    output logic                              err_spread,
    output logic [$clog2(MAX_RETRY+1)-1:0]    retry_cnt
`ifdef FREQ_MEAS_RANGE_CHECK_EN
    ,
    output logic                              err_range
`endif
);

    localparam int LOG2N   = $clog2(NUM_SAMPLES);
    localparam int SUM_W   = PERIOD_W + LOG2N;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int CLR_W   = $clog2(CLEAR_CYCLES + 1);
    localparam int TMO_W   = $clog2(STABLE_TIMEOUT + 1);
    localparam int GAP_W   = $clog2(SAMPLE_GAP + 1);
    localparam int SMP_W   = $clog2(NUM_SAMPLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_REPORT  = 3'd5;
    localparam logic [2:0] S_FAIL    = 3'd6;

    logic [2:0]          state_q, state_d;
    logic                cont_q, cont_d;
    logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [SMP_W-1:0]    smp_cnt_q, smp_cnt_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [PERIOD_W-1:0] min_q, min_d;
    logic [PERIOD_W-1:0] max_q, max_d;
    logic [PERIOD_W-1:0] result_q, result_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_spread_q, err_spread_d;
`ifdef FREQ_MEAS_RANGE_CHECK_EN
    logic                err_range_q, err_range_d;
`endif

    logic [PERIOD_W-1:0] spread;
    logic [PERIOD_W-1:0] avg;
    logic [SUM_W-1:0]    period_ext;
    logic                range_bad;
    logic                check_ok;

    assign spread     = max_q - min_q;
    assign avg        = PERIOD_W'(sum_q >> LOG2N);
    assign period_ext = SUM_W'(det_period);
`ifdef FREQ_MEAS_RANGE_CHECK_EN
    assign range_bad  = (avg < PERIOD_W'(MIN_PERIOD)) || (avg > PERIOD_W'(MAX_PERIOD));
`else
    assign range_bad  = 1'b0;
`endif
    assign check_ok   = (spread <= PERIOD_W'(TOL)) && !range_bad;

    // Per-state counters default to zero, so each is already cleared when its state is entered.
    always_comb begin
        state_d       = state_q;
        cont_d        = cont_q;
        clr_cnt_d     = '0;
        tmo_cnt_d     = '0;
        gap_cnt_d     = '0;
        smp_cnt_d     = '0;
        sum_d         = sum_q;
        min_d         = min_q;
        max_d         = max_q;
        result_d      = result_q;
        retry_d       = retry_q;
        err_timeout_d = err_timeout_q;
        err_spread_d  = err_spread_q;
`ifdef FREQ_MEAS_RANGE_CHECK_EN
        err_range_d   = err_range_q;
`endif
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d       = S_CLEAR;
                        cont_d        = continuous;
                        retry_d       = '0;
                        err_timeout_d = 1'b0;
                        err_spread_d  = 1'b0;
`ifdef FREQ_MEAS_RANGE_CHECK_EN
                        err_range_d   = 1'b0;
`endif
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) state_d = S_WAIT;
                    else clr_cnt_d = clr_cnt_q + 1'b1;
                end
                S_WAIT: begin
                    // Stable is checked first so it wins a tie with the timeout.
                    if (det_stable) begin
                        state_d = S_CAPTURE;
                    end else if (tmo_cnt_q == TMO_W'(STABLE_TIMEOUT - 1)) begin
                        state_d       = S_FAIL;
                        err_timeout_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (!det_stable) begin
                        state_d = S_WAIT;
                    end else begin
                        smp_cnt_d = smp_cnt_q;
                        gap_cnt_d = (gap_cnt_q == GAP_W'(SAMPLE_GAP - 1)) ? '0 : gap_cnt_q + 1'b1;
                        if (gap_cnt_q == '0) begin
                            // First reading seeds the accumulators instead of merging.
                            if (smp_cnt_q == '0) begin
                                sum_d = period_ext;
                                min_d = det_period;
                                max_d = det_period;
                            end else begin
                                sum_d = sum_q + period_ext;
                                if (det_period < min_q) min_d = det_period;
                                if (det_period > max_q) max_d = det_period;
                            end
                            smp_cnt_d = smp_cnt_q + 1'b1;
                            if (smp_cnt_q == SMP_W'(NUM_SAMPLES - 1)) state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (check_ok) begin
                        result_d = avg;
                        state_d  = S_REPORT;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_FAIL;
`ifdef FREQ_MEAS_RANGE_CHECK_EN
                        if (range_bad) err_range_d = 1'b1;
                        else err_spread_d = 1'b1;
`else
                        err_spread_d = 1'b1;
`endif
                    end
                end
                S_REPORT: begin
                    if (result_ready) begin
                        if (cont_q) begin
                            state_d = S_CLEAR;
                            retry_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_FAIL:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cont_q        <= 1'b0;
            clr_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            smp_cnt_q     <= '0;
            sum_q         <= '0;
            min_q         <= '0;
            max_q         <= '0;
            result_q      <= '0;
            retry_q       <= '0;
            err_timeout_q <= 1'b0;
            err_spread_q  <= 1'b0;
`ifdef FREQ_MEAS_RANGE_CHECK_EN
            err_range_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cont_q        <= cont_d;
            clr_cnt_q     <= clr_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            smp_cnt_q     <= smp_cnt_d;
            sum_q         <= sum_d;
            min_q         <= min_d;
            max_q         <= max_d;
            result_q      <= result_d;
            retry_q       <= retry_d;
            err_timeout_q <= err_timeout_d;
            err_spread_q  <= err_spread_d;
`ifdef FREQ_MEAS_RANGE_CHECK_EN
            err_range_q   <= err_range_d;
`endif
        end
    end

    assign det_clear     = (state_q == S_CLEAR);
    assign result_valid  = (state_q == S_REPORT);
    assign busy          = (state_q != S_IDLE);
    assign result_period = result_q;
    assign retry_cnt     = retry_q;
    assign err_timeout   = err_timeout_q;
    assign err_spread    = err_spread_q;
`ifdef FREQ_MEAS_RANGE_CHECK_EN
    assign err_range     = err_range_q;
`endif

endmodule
